dht11_cmd_responder: RTL and testbench

// - Sits directly downstream of the DHT11 single-wire reader, between it and the UART TX.
// - Holds the most recent valid DHT11 frame and tracks whether the sensor is alive.
// - Decodes 8-bit request codes from the UART RX and answers each with a 2-byte response:
//   a response code followed by a value.
// - Serialises the two bytes to the UART TX through a start/done handshake.

---
 rtl/dht11_cmd_responder.sv | 159 +++++++++++++++
 tb/tb_dht11_cmd_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dht11_cmd_responder.sv
// DHT11 command responder: keeps the latest sensor frame, answers UART request codes with 2-byte replies.
// Optional periodic reporting is compiled in with `define CONTINUOUS_MODE_EN.
module dht11_cmd_responder #(
  parameter int STALE_CYC       = 150_000_000,
  parameter int CONT_PERIOD_CYC = 100_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] sensor_data,
  input  logic        sensor_valid,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  output logic        busy,
  output logic        cmd_dropped,
  output logic        cont_active
);
  localparam int SW = $clog2(STALE_CYC + 1);

  typedef enum logic [2:0] {IDLE, DECODE, SEND0, WAIT0, SEND1, WAIT1} state_t;

  state_t        state, state_nx;
  logic [31:0]   frame;
  logic [SW-1:0] stale_cnt;
  logic          sensor_ok;
  logic [7:0]    code_q, b1_q, dec_b0, dec_b1;
  logic          tick_go;

  // sensor_ok falls on the same edge the counter reaches STALE_CYC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame     <= '0;
      stale_cnt <= '0;
      sensor_ok <= 1'b0;
    end else if (sensor_valid) begin
      frame     <= sensor_data;
      stale_cnt <= '0;
      sensor_ok <= 1'b1;
    end else if (stale_cnt >= SW'(STALE_CYC - 1)) begin
      stale_cnt <= SW'(STALE_CYC);
      sensor_ok <= 1'b0;
    end else begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

`ifdef CONTINUOUS_MODE_EN
  localparam int CW = $clog2(CONT_PERIOD_CYC);
  logic [CW-1:0] cont_cnt;
  logic          cont_q, cont_sel, pending, tick_q, tick;

  assign tick        = cont_q && (cont_cnt == CW'(CONT_PERIOD_CYC - 1));
  assign tick_go     = pending && !cmd_valid;
  assign cont_active = cont_q;

  // a tick seen while busy (or colliding with a command) waits in pending
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_cnt <= '0;
      cont_q   <= 1'b0;
      cont_sel <= 1'b0;
      pending  <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      if (cont_q) cont_cnt <= tick ? '0 : cont_cnt + 1'b1;
      if (state == IDLE) begin
        tick_q <= tick_go;
        if (tick_go) pending <= 1'b0;
      end
      if (tick) pending <= 1'b1;
      if (state == DECODE) begin
        if (tick_q) begin
          if (!sensor_ok) begin
            cont_q  <= 1'b0;
            pending <= 1'b0;
          end
        end else if ((code_q == 8'h03 || code_q == 8'h04) && sensor_ok) begin
          cont_q   <= 1'b1;
          cont_sel <= code_q[2];
          cont_cnt <= '0;
          pending  <= 1'b0;
        end else if (code_q == 8'h05) begin
          cont_q   <= 1'b0;
          cont_cnt <= '0;
          pending  <= 1'b0;
        end
      end
    end
  end
`else
  assign tick_go     = 1'b0;
  assign cont_active = 1'b0;
`endif

  always_comb begin
    dec_b0 = 8'hEF;
    dec_b1 = code_q;
`ifdef CONTINUOUS_MODE_EN
    if (tick_q) begin
      if (!sensor_ok)    {dec_b0, dec_b1} = 16'h1F00;
      else if (cont_sel) {dec_b0, dec_b1} = {8'h0E, frame[31:24]};
      else               {dec_b0, dec_b1} = {8'h0D, frame[15:8]};
    end else
`endif
    case (code_q)
      8'h00: {dec_b0, dec_b1} = sensor_ok ? 16'h0700 : 16'h1F00;
      8'h01: {dec_b0, dec_b1} = sensor_ok ? {8'h09, frame[15:8]}  : 16'h1F00;
      8'h02: {dec_b0, dec_b1} = sensor_ok ? {8'h08, frame[31:24]} : 16'h1F00;
`ifdef CONTINUOUS_MODE_EN
      8'h03: {dec_b0, dec_b1} = sensor_ok ? {8'h0D, frame[15:8]}  : 16'h1F00;
      8'h04: {dec_b0, dec_b1} = sensor_ok ? {8'h0E, frame[31:24]} : 16'h1F00;
      8'h05: {dec_b0, dec_b1} = 16'h0A00;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid || tick_go) state_nx = DECODE;
      DECODE:  state_nx = SEND0;
      SEND0:   state_nx = WAIT0;
      WAIT0:   if (tx_done) state_nx = SEND1;
      SEND1:   state_nx = WAIT1;
      WAIT1:   if (tx_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_start    = (state == SEND0) || (state == SEND1);
    busy        = (state != IDLE);
    cmd_dropped = cmd_valid && (state != IDLE);
  end

  // response is snapshotted in DECODE so a frame update cannot tear it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_q  <= '0;
      b1_q    <= '0;
      tx_byte <= '0;
    end else begin
      if (state == IDLE && cmd_valid) code_q <= cmd_code;
      if (state == DECODE) begin
        tx_byte <= dec_b0;
        b1_q    <= dec_b1;
      end
      if (state == WAIT0 && tx_done) tx_byte <= b1_q;
    end
  end
endmodule

// File: tb/tb_dht11_cmd_responder.sv
// Directed bench for dht11_cmd_responder with a small UART TX handshake responder.
module tb_dht11_cmd_responder;
  localparam int STALE = 500;
  localparam int PERIOD = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sensor_data = '0;
  logic        sensor_valid = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_code = '0;
  logic        tx_done = 1'b0;
  logic        tx_start, busy, cmd_dropped, cont_active;
  logic [7:0]  tx_byte;

  int checks = 0;
  int failures = 0;
  int n_starts = 0;

  dht11_cmd_responder #(.STALE_CYC(STALE), .CONT_PERIOD_CYC(PERIOD)) dut (
    .clock(clock), .reset(reset), .sensor_data(sensor_data), .sensor_valid(sensor_valid),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .tx_done(tx_done), .tx_start(tx_start),
    .tx_byte(tx_byte), .busy(busy), .cmd_dropped(cmd_dropped), .cont_active(cont_active)
  );

  always #10 clock = ~clock;
  always @(posedge clock) if (reset && tx_start) n_starts++;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // waits for a response and plays the UART side; observations only, no checks
  task automatic serve(output logic [7:0] b0, output logic [7:0] b1, output int lat,
                       output logic held, output logic busy_done, output logic busy_after);
    int k;
    lat = 0;
    while (!tx_start && lat < 2000) begin step(); lat++; end
    b0 = tx_byte;
    repeat (3) step();
    held = (tx_byte === b0) && !tx_start;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    k = 0;
    while (!tx_start && k < 20) begin step(); k++; end
    b1 = tx_byte;
    step();
    tx_done = 1'b1; busy_done = busy; step(); tx_done = 1'b0;
    busy_after = busy;
  endtask

  task automatic run_cmd(input logic [7:0] code, output logic [7:0] b0, output logic [7:0] b1,
                         output int lat, output logic busy1, output logic held,
                         output logic bd, output logic ba);
    cmd_code = code; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    busy1 = busy;
    serve(b0, b1, lat, held, bd, ba);
    lat = lat + 1;
  endtask

  task automatic test_reset;
    checks++;
    if ({tx_start, tx_byte, busy, cmd_dropped, cont_active} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got start=%b byte=%h busy=%b drop=%b cont=%b want all 0",
               tx_start, tx_byte, busy, cmd_dropped, cont_active);
    end
  endtask

  task automatic test_not_ok;
    logic [7:0] b0, b1; int lat; logic b1c, h, bd, ba;
    run_cmd(8'h00, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h1F00) begin failures++; $display("FAIL notok_bytes got %h %h want 1f 00", b0, b1); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL notok_latency got %0d want 2", lat); end
    checks++; if (b1c !== 1'b1) begin failures++; $display("FAIL busy_n1 got %b want 1", b1c); end
    checks++; if (h !== 1'b1) begin failures++; $display("FAIL tx_byte_hold got %b want 1", h); end
    checks++; if (bd !== 1'b1) begin failures++; $display("FAIL busy_at_last_done got %b want 1", bd); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL busy_after_done got %b want 0", ba); end
  endtask

  task automatic test_read;
    logic [7:0] b0, b1; int lat; logic b1c, h, bd, ba;
    sensor_data = 32'h3A00_1900; sensor_valid = 1'b1; step();
    run_cmd(8'h01, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0919) begin failures++; $display("FAIL temp_bytes got %h %h want 09 19", b0, b1); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL temp_latency got %0d want 2", lat); end
    run_cmd(8'h02, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h083A) begin failures++; $display("FAIL hum_bytes got %h %h want 08 3a", b0, b1); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL hum_latency got %0d want 2", lat); end
    run_cmd(8'h00, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0700) begin failures++; $display("FAIL status_ok got %h %h want 07 00", b0, b1); end
  endtask

  task automatic test_unknown;
    logic [7:0] b0, b1; int lat; logic b1c, h, bd, ba;
    run_cmd(8'h7F, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'hEF7F) begin failures++; $display("FAIL unknown_7f got %h %h want ef 7f", b0, b1); end
`ifndef CONTINUOUS_MODE_EN
    run_cmd(8'h03, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'hEF03) begin failures++; $display("FAIL unknown_03 got %h %h want ef 03", b0, b1); end
    checks++; if (cont_active !== 1'b0) begin failures++; $display("FAIL cont_tied got %b want 0", cont_active); end
`endif
  endtask

  task automatic test_dropped;
    int k;
    k = n_starts;
    cmd_code = 8'h01; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    step(); step();
    cmd_code = 8'h02; cmd_valid = 1'b1; #1;
    checks++; if (cmd_dropped !== 1'b1) begin failures++; $display("FAIL dropped_strobe got %b want 1", cmd_dropped); end
    step(); cmd_valid = 1'b0; #1;
    checks++; if (cmd_dropped !== 1'b0) begin failures++; $display("FAIL dropped_clear got %b want 0", cmd_dropped); end
    tx_done = 1'b1; step(); tx_done = 1'b0;
    step();
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (10) step();
    checks++; if (n_starts - k !== 2) begin failures++; $display("FAIL dropped_starts got %0d want 2", n_starts - k); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dropped_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_done_idle;
    int k;
    k = n_starts;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (5) step();
    checks++;
    if (n_starts != k || busy !== 1'b0) begin
      failures++; $display("FAIL done_in_idle got starts=%0d busy=%b want 0 0", n_starts - k, busy);
    end
  endtask

  task automatic test_stale;
    logic [7:0] b0, b1; int lat; logic b1c, h, bd, ba;
    sensor_valid = 1'b1; step(); sensor_valid = 1'b0;
    repeat (400) step();
    run_cmd(8'h01, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0919) begin failures++; $display("FAIL stale_early got %h %h want 09 19", b0, b1); end
    sensor_valid = 1'b1; step(); sensor_valid = 1'b0;
    repeat (STALE) step();
    run_cmd(8'h01, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h1F00) begin failures++; $display("FAIL stale_temp got %h %h want 1f 00", b0, b1); end
    run_cmd(8'h02, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h1F00) begin failures++; $display("FAIL stale_hum got %h %h want 1f 00", b0, b1); end
  endtask

  task automatic test_reset_mid;
    int k;
    cmd_code = 8'h00; cmd_valid = 1'b1; step(); cmd_valid = 1'b0;
    step(); step();
    reset = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || cont_active !== 1'b0) begin
      failures++; $display("FAIL reset_mid got busy=%b start=%b cont=%b want 0 0 0", busy, tx_start, cont_active);
    end
    step(); reset = 1'b1;
    k = n_starts;
    tx_done = 1'b1; step(); tx_done = 1'b0;
    repeat (10) step();
    checks++; if (n_starts != k) begin failures++; $display("FAIL reset_mid_starts got %0d want 0", n_starts - k); end
  endtask

`ifdef CONTINUOUS_MODE_EN
  task automatic test_continuous;
    logic [7:0] b0, b1; int lat, k; logic b1c, h, bd, ba;
    sensor_data = 32'h3A00_1900; sensor_valid = 1'b1; step();
    run_cmd(8'h03, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0D19) begin failures++; $display("FAIL cont_start got %h %h want 0d 19", b0, b1); end
    checks++; if (cont_active !== 1'b1) begin failures++; $display("FAIL cont_active_on got %b want 1", cont_active); end
    serve(b0, b1, lat, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0D19) begin failures++; $display("FAIL cont_tick got %h %h want 0d 19", b0, b1); end
    checks++; if (lat < 980 || lat > 1010) begin failures++; $display("FAIL cont_period got %0d want about 1000", lat); end
    run_cmd(8'h05, b0, b1, lat, b1c, h, bd, ba);
    checks++; if ({b0, b1} !== 16'h0A00) begin failures++; $display("FAIL cont_stop got %h %h want 0a 00", b0, b1); end
    checks++; if (cont_active !== 1'b0) begin failures++; $display("FAIL cont_active_off got %b want 0", cont_active); end
    k = n_starts;
    repeat (1200) step();
    checks++; if (n_starts != k) begin failures++; $display("FAIL cont_silent got %0d want 0", n_starts - k); end
  endtask
`endif

  initial begin
    repeat (3) step();
    test_reset();
    reset = 1'b1; step();
    test_not_ok();
    test_read();
    test_unknown();
    test_dropped();
    test_done_idle();
    test_stale();
    test_reset_mid();
`ifdef CONTINUOUS_MODE_EN
    test_continuous();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
